// File: rtl/streaming_fifo_pkg.sv
// ---------------------------------------------------------------------------
// streaming_fifo_pkg
//   Shared helpers for the parametrised stream FIFO:
//     cnt_width(depth)  - width of an occupancy value that must hold 0..depth
//     is_pow2(v)        - power-of-two test for the storage depth
//     params_legal(...) - full parameter legality check, evaluated at
//                         elaboration by the FIFO top so that an illegal
//                         configuration stops the build
// ---------------------------------------------------------------------------
package streaming_fifo_pkg;

    // Occupancy runs 0..depth inclusive, hence depth+1 distinct values.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Legal when: WIDTH in 1..1024, DEPTH a power of two in 2..65536,
    // and AE_THRESH < AF_THRESH <= DEPTH.
    function automatic bit params_legal(input int width, input int depth,
                                        input int ae_thresh, input int af_thresh);
        return (width >= 1) && (width <= 1024) &&
               is_pow2(depth) && (depth <= 65536) &&
               (ae_thresh < af_thresh) && (af_thresh <= depth);
    endfunction

endpackage

// File: rtl/streaming_fifo_hwm.sv
// ---------------------------------------------------------------------------
// streaming_fifo_hwm
//   High-water-mark monitor: remembers the largest occupancy the FIFO has
//   reached since reset or since the last clear. It watches count_next (the
//   occupancy the FIFO register is about to take) so the mark is in step with
//   the registered count after every edge.
//
//   Ports
//     ap_clk     in   clock, rising edge
//     ap_rst     in   synchronous active-high reset, clears the mark
//     count_next in   occupancy the FIFO holds after this edge
//     clear      in   restart tracking from count_next (wins over the max)
//     hwm        out  registered high-water mark
// ---------------------------------------------------------------------------
module streaming_fifo_hwm
    import streaming_fifo_pkg::*;
#(
    parameter int DEPTH = 16384
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [cnt_width(DEPTH)-1:0]  count_next,
    input  logic                         clear,
    output logic [cnt_width(DEPTH)-1:0]  hwm
);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            hwm <= '0;
        end else if (clear) begin
            hwm <= count_next;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end

endmodule

// File: rtl/streaming_fifo_param.sv
// ---------------------------------------------------------------------------
// streaming_fifo_param
//   Parametrised first-word-fall-through AXI-Stream FIFO for buffering
//   between two streaming compute layers. Reports occupancy, free space,
//   programmable almost-full / almost-empty flags and, when the macro
//   STREAMING_FIFO_HWM_EN is defined, an occupancy high-water mark.
//   Without the macro hwm is tied to 0 and hwm_clr is ignored; the port
//   list is the same in both builds.
//
//   Parameters
//     WIDTH      data bits per beat (1..1024)
//     DEPTH      storage slots, power of two (2..65536)
//     AF_THRESH  almost_full  when count >= AF_THRESH
//     AE_THRESH  almost_empty when count <= AE_THRESH
//
//   Ports
//     ap_clk        in   clock, rising edge
//     ap_rst        in   synchronous active-high reset
//     in0_V_TDATA   in   input beat
//     in0_V_TVALID  in   input beat valid
//     in0_V_TREADY  out  FIFO can accept a beat (low during reset)
//     out_V_TDATA   out  head-of-queue beat (asynchronous read)
//     out_V_TVALID  out  head is valid (FIFO not empty)
//     out_V_TREADY  in   consumer takes the head beat
//     count         out  current occupancy
//     free          out  DEPTH - count
//     almost_full   out  occupancy flag
//     almost_empty  out  occupancy flag
//     hwm           out  maximum occupancy since reset / last clear
//     hwm_clr       in   synchronous high-water-mark clear
// ---------------------------------------------------------------------------
module streaming_fifo_param
    import streaming_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16384,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [WIDTH-1:0]             in0_V_TDATA,
    input  logic                         in0_V_TVALID,
    output logic                         in0_V_TREADY,
    output logic [WIDTH-1:0]             out_V_TDATA,
    output logic                         out_V_TVALID,
    input  logic                         out_V_TREADY,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic [cnt_width(DEPTH)-1:0]  free,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  hwm,
    input  logic                         hwm_clr
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    if (!params_legal(WIDTH, DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_params
        $error("streaming_fifo_param: illegal WIDTH/DEPTH/AE_THRESH/AF_THRESH");
    end

    // NOTE: storage has no reset; occupancy and pointers alone define what is
    // valid, so a reset discards contents without clearing the array.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Ready depends only on the registered count, so a pop into a full FIFO
    // frees space for the following cycle, never the same one.
    assign in0_V_TREADY = !ap_rst && (count != FULL_CNT);
    assign out_V_TVALID = (count != '0);
    assign out_V_TDATA  = mem[rd_ptr];

    assign push = in0_V_TVALID && in0_V_TREADY;
    assign pop  = out_V_TVALID && out_V_TREADY;

    // NOTE: the default assignment first keeps this block free of latches
    // whatever branch is taken.
    always_comb begin
        count_next = count;
        if (ap_rst) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits and wrap on overflow.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count_next;
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= in0_V_TDATA;
        end
    end

    assign free         = FULL_CNT - count;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

`ifdef STREAMING_FIFO_HWM_EN
    streaming_fifo_hwm #(
        .DEPTH (DEPTH)
    ) u_hwm (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .count_next (count_next),
        .clear      (hwm_clr),
        .hwm        (hwm)
    );
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm            = '0;
`endif

endmodule

// File: tb/tb_streaming_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_streaming_fifo_param
//   Directed self-checking bench for streaming_fifo_param at DEPTH=16,
//   WIDTH=8 (AF_THRESH=14, AE_THRESH=1). Inputs change and outputs are
//   sampled 1 ns after each rising edge. Expected hwm values follow the
//   STREAMING_FIFO_HWM_EN build setting.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_streaming_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef STREAMING_FIFO_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic [WIDTH-1:0] in0_V_TDATA;
    logic             in0_V_TVALID;
    logic             in0_V_TREADY;
    logic [WIDTH-1:0] out_V_TDATA;
    logic             out_V_TVALID;
    logic             out_V_TREADY;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] hwm;
    logic             hwm_clr;

    int n_checks = 0;
    int n_bad    = 0;

    logic [WIDTH-1:0] sb[$];

    always #5 ap_clk = ~ap_clk;

    streaming_fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .in0_V_TDATA  (in0_V_TDATA),
        .in0_V_TVALID (in0_V_TVALID),
        .in0_V_TREADY (in0_V_TREADY),
        .out_V_TDATA  (out_V_TDATA),
        .out_V_TVALID (out_V_TVALID),
        .out_V_TREADY (out_V_TREADY),
        .count        (count),
        .free         (free),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .hwm          (hwm),
        .hwm_clr      (hwm_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push_beat(input logic [WIDTH-1:0] d);
        in0_V_TVALID = 1'b1;
        in0_V_TDATA  = d;
        tick();
        in0_V_TVALID = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [WIDTH-1:0] exp);
        check({tag, "_tvalid"}, 32'(out_V_TVALID), 32'd1);
        check({tag, "_tdata"}, 32'(out_V_TDATA), 32'(exp));
        out_V_TREADY = 1'b1;
        tick();
        out_V_TREADY = 1'b0;
    endtask

    initial begin
        ap_rst       = 1'b1;
        in0_V_TDATA  = '0;
        in0_V_TVALID = 1'b0;
        out_V_TREADY = 1'b0;
        hwm_clr      = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        check("rst_count",  32'(count), 32'd0);
        check("rst_free",   32'(free), 32'd16);
        check("rst_tvalid", 32'(out_V_TVALID), 32'd0);
        check("rst_tready", 32'(in0_V_TREADY), 32'd0);
        check("rst_ae",     32'(almost_empty), 32'd1);
        check("rst_af",     32'(almost_full), 32'd0);
        check("rst_hwm",    32'(hwm), 32'd0);
        ap_rst = 1'b0;
        #1;
        check("rst_release_tready", 32'(in0_V_TREADY), 32'd1);

        // ---- fill 0x00..0x0F with the consumer stalled ----
        for (int i = 0; i < 16; i++) begin
            check("fill_tready", 32'(in0_V_TREADY), 32'd1);
            push_beat(WIDTH'(i));
            if (i == 12) check("af_at13", 32'(almost_full), 32'd0);
            if (i == 13) check("af_at14", 32'(almost_full), 32'd1);
        end
        check("full_tready", 32'(in0_V_TREADY), 32'd0);
        check("full_count",  32'(count), 32'd16);
        check("full_free",   32'(free), 32'd0);
        check("full_af",     32'(almost_full), 32'd1);
        check("full_ae",     32'(almost_empty), 32'd0);
        check("full_hwm",    32'(hwm), HWM_ON ? 32'd16 : 32'd0);

        // ---- drain in order ----
        for (int i = 0; i < 16; i++) begin
            pop_check("drain", WIDTH'(i));
            if (i == 13) check("ae_at2", 32'(almost_empty), 32'd0);
            if (i == 14) check("ae_at1", 32'(almost_empty), 32'd1);
        end
        check("drain_count",  32'(count), 32'd0);
        check("drain_ae",     32'(almost_empty), 32'd1);
        check("drain_tvalid", 32'(out_V_TVALID), 32'd0);

        // ---- full FIFO, pop with push pending ----
        for (int i = 0; i < 16; i++) push_beat(WIDTH'(8'h10 + i));
        in0_V_TVALID = 1'b1;
        in0_V_TDATA  = 8'h80;
        out_V_TREADY = 1'b1;
        check("fullpop_tready", 32'(in0_V_TREADY), 32'd0);
        tick();
        out_V_TREADY = 1'b0;
        check("fullpop_count",  32'(count), 32'd15);
        check("fullpop_tready_next", 32'(in0_V_TREADY), 32'd1);
        tick();
        in0_V_TVALID = 1'b0;
        check("fullpop_refill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++)
            pop_check("fullpop_drain", (i < 15) ? WIDTH'(8'h11 + i) : 8'h80);
        check("fullpop_empty", 32'(count), 32'd0);

        // ---- steady push+pop at count 5 across pointer wrap ----
        for (int i = 0; i < 5; i++) begin
            push_beat(WIDTH'(8'h20 + i));
            sb.push_back(WIDTH'(8'h20 + i));
        end
        in0_V_TVALID = 1'b1;
        out_V_TREADY = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in0_V_TDATA = WIDTH'(8'h30 + i);
            #0;
            check("stream_tdata", 32'(out_V_TDATA), 32'(sb.pop_front()));
            sb.push_back(WIDTH'(8'h30 + i));
            tick();
        end
        in0_V_TVALID = 1'b0;
        out_V_TREADY = 1'b0;
        check("stream_count", 32'(count), 32'd5);
        while (sb.size() > 0) pop_check("stream_drain", sb.pop_front());
        check("stream_empty", 32'(count), 32'd0);

        // ---- fall-through from empty, no same-cycle bypass ----
        in0_V_TVALID = 1'b1;
        in0_V_TDATA  = 8'hA5;
        #1;
        check("ft_no_bypass", 32'(out_V_TVALID), 32'd0);
        tick();
        in0_V_TVALID = 1'b0;
        check("ft_tvalid", 32'(out_V_TVALID), 32'd1);
        check("ft_tdata",  32'(out_V_TDATA), 32'hA5);
        check("ft_count",  32'(count), 32'd1);
        out_V_TREADY = 1'b1;
        tick();
        out_V_TREADY = 1'b0;
        check("ft_pop_count", 32'(count), 32'd0);

        // ---- reset mid-operation ----
        for (int i = 0; i < 9; i++) push_beat(WIDTH'(8'h40 + i));
        check("pre_rst_count", 32'(count), 32'd9);
        ap_rst = 1'b1;
        tick();
        check("mid_rst_count",  32'(count), 32'd0);
        check("mid_rst_tvalid", 32'(out_V_TVALID), 32'd0);
        check("mid_rst_tready", 32'(in0_V_TREADY), 32'd0);
        check("mid_rst_hwm",    32'(hwm), 32'd0);
        check("mid_rst_free",   32'(free), 32'd16);
        ap_rst = 1'b0;
        #1;
        push_beat(8'h50);
        push_beat(8'h51);
        pop_check("refill0", 8'h50);
        pop_check("refill1", 8'h51);
        check("refill_tvalid", 32'(out_V_TVALID), 32'd0);

        // ---- high-water mark ----
        for (int i = 0; i < 12; i++) push_beat(WIDTH'(8'h60 + i));
        for (int i = 0; i < 9; i++) pop_check("hwm_drain", WIDTH'(8'h60 + i));
        check("hwm_count3", 32'(count), 32'd3);
        check("hwm_12",     32'(hwm), HWM_ON ? 32'd12 : 32'd0);
        hwm_clr = 1'b1;
        push_beat(8'h70);
        hwm_clr = 1'b0;
        check("hwm_clr_count", 32'(count), 32'd4);
        check("hwm_clr",       32'(hwm), HWM_ON ? 32'd4 : 32'd0);
        push_beat(8'h71);
        check("hwm_5", 32'(hwm), HWM_ON ? 32'd5 : 32'd0);
        for (int i = 0; i < 3; i++) pop_check("hwm_tail", WIDTH'(8'h69 + i));
        pop_check("hwm_tail", 8'h70);
        pop_check("hwm_tail", 8'h71);
        check("hwm_hold", 32'(hwm), HWM_ON ? 32'd5 : 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
